imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared constants and FSM state encoding for the instruction-memory
//            loader (instruction bus width, default memory depth, states).
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Width of one instruction word written into instruction memory
  localparam int unsigned INSTR_BUS_BITS = 32;

  // Default instruction-memory depth in words
  localparam int unsigned IMEM_WORDS_DEFAULT = 4096;

  // Loader session states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // True while a session is actively consuming the byte stream
  function automatic logic is_busy(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Purpose  : Assembles accepted stream bytes little-endian into instruction
//            words; flags the byte that completes a word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_byte_en,
  input  logic [7:0]                i_byte,
  output logic [INSTR_BUS_BITS-1:0] o_word,
  output logic                      o_word_ready
);

  logic [1:0]                r_idx;
  logic [INSTR_BUS_BITS-1:0] r_shift;

  // Shift each byte in from the top so the first byte ends up in [7:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else if (i_byte_en) begin
      r_shift <= {i_byte, r_shift[INSTR_BUS_BITS-1:8]};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle
  assign o_word       = {i_byte, r_shift[INSTR_BUS_BITS-1:8]};
  assign o_word_ready = i_byte_en && (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Parses a byte stream (16-bit LE word count + LE instruction words)
//            and writes the words into instruction memory, holding the core
//            in reset until a session completes cleanly.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int unsigned ADDR_BITS  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      imem_we,
  output logic [ADDR_BITS-1:0]      imem_waddr,
  output logic [INSTR_BUS_BITS-1:0] imem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      cpu_hold
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_hdr_lo;
  logic [15:0]               r_n;
  logic [ADDR_BITS:0]        r_cnt;      // one extra bit so N == IMEM_WORDS never wraps
  logic                      r_done;
  logic                      r_err;
  logic                      r_we;
  logic [ADDR_BITS-1:0]      r_waddr;
  logic [INSTR_BUS_BITS-1:0] r_wdata;

  logic                      w_busy;
  logic                      w_accept;
  logic                      w_start_go;
  logic [15:0]               w_hdr;
  logic                      w_hdr_zero;
  logic                      w_hdr_big;
  logic                      w_pack_en;
  logic [INSTR_BUS_BITS-1:0] w_word;
  logic                      w_word_ready;
  logic [ADDR_BITS:0]        w_cnt_inc;
  logic                      w_last;

  assign w_busy     = is_busy(r_state);
  assign w_accept   = byte_valid && byte_ready;
  assign w_start_go = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_hdr      = {byte_data, r_hdr_lo};
  assign w_hdr_zero = (w_hdr == 16'd0);
  assign w_hdr_big  = (32'(w_hdr) > IMEM_WORDS);
  assign w_pack_en  = w_accept && (r_state == ST_DATA);
  assign w_cnt_inc  = r_cnt + {{ADDR_BITS{1'b0}}, 1'b1};
  assign w_last     = w_word_ready && (32'(w_cnt_inc) == 32'(r_n));

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start_go),
    .i_byte_en    (w_pack_en),
    .i_byte       (byte_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; start is only honoured in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_HDR0;
      ST_HDR0:          if (w_accept) w_state_nxt = ST_HDR1;
      ST_HDR1: begin
        if (w_accept) begin
          if (w_hdr_zero || w_hdr_big) w_state_nxt = ST_DONE;
          else                         w_state_nxt = ST_DATA;
        end
      end
      ST_DATA:          if (w_last) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Header capture, word counter, status flags and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_lo <= 8'd0;
      r_n      <= 16'd0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_go) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_accept && (r_state == ST_HDR0)) r_hdr_lo <= byte_data;
      if (w_accept && (r_state == ST_HDR1)) begin
        r_n <= w_hdr;
        if (w_hdr_zero) r_done <= 1'b1;
        if (w_hdr_big) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
      end
      if (w_word_ready) begin
        r_we    <= 1'b1;
        r_waddr <= r_cnt[ADDR_BITS-1:0];
        r_wdata <= w_word;
        r_cnt   <= w_cnt_inc;
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  // No byte is taken during the write cycle, giving one bubble per word
  assign byte_ready = w_busy && !r_we;
  assign busy       = w_busy;
  assign done       = r_done;
  assign err        = r_err;
  // Core stays held until a session completes without error
  assign cpu_hold   = w_busy || ((r_state == ST_IDLE) && !r_done) || r_err;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;

endmodule
`default_nettype wire
